// File: rtl/uart_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and the shift-engine state encoding.
package uart_pkg;

    localparam logic [1:0] UART_REG_TXDATA  = 2'd0;
    localparam logic [1:0] UART_REG_STATUS  = 2'd1;
    localparam logic [1:0] UART_REG_DIVISOR = 2'd2;

    localparam int UART_STAT_FULL    = 0;
    localparam int UART_STAT_IDLE    = 1;
    localparam int UART_STAT_OVF     = 2;
    localparam int UART_STAT_CNT_LSB = 8;
    localparam int UART_STAT_CNT_W   = 5;

    typedef enum logic [1:0] {
        UART_ST_IDLE  = 2'd0,
        UART_ST_START = 2'd1,
        UART_ST_DATA  = 2'd2,
        UART_ST_STOP  = 2'd3
    } uart_state_t;

    // A programmed divisor of zero behaves as one clock per bit.
    function automatic logic [15:0] uart_eff_div(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with show-ahead output. A push while full is accepted only
// when a pop happens in the same cycle, leaving the count unchanged.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: register decode, divisor, read mux and
// shift engine. Define UART_TX_FIFO_EN for a 2^FIFO_DEPTH_LOG2 FIFO, else a 1-byte holding register.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter logic [15:0] DIV_RESET       = 16'd434,
    parameter int          FIFO_DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel,
    input  logic        en,
    input  logic [1:0]  addr,
    input  logic [3:0]  we,
    input  logic [31:0] d,
    output logic [31:0] q,
    output logic        tx
);
    logic        access;
    logic        wr;
    logic        rd;
    logic        push;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;
    logic [UART_STAT_CNT_W-1:0] cnt_stat;

    logic [15:0] div;
    logic        ovf;
    logic [31:0] status;
    logic [31:0] rdata;

    uart_state_t state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        bit_end;
    logic [15:0] period;

    logic        unused;
    assign unused = ^{d[31:16], we[3:2]};

    assign access = sel & en;
    assign wr     = access & (|we);
    assign rd     = access & ~(|we);
    assign push   = wr & (addr == UART_REG_TXDATA) & we[0];

`ifdef UART_TX_FIFO_EN
    logic [FIFO_DEPTH_LOG2:0] fifo_count;

    sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (d[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign cnt_stat = UART_STAT_CNT_W'(fifo_count);
`else
    logic       hold_vld;
    logic [7:0] hold_data;

    assign fifo_full  = hold_vld;
    assign fifo_empty = ~hold_vld;
    assign fifo_dout  = hold_data;
    assign cnt_stat   = UART_STAT_CNT_W'(hold_vld);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_vld  <= 1'b0;
            hold_data <= 8'h00;
        end else if (push && (!hold_vld || pop)) begin
            hold_vld  <= 1'b1;
            hold_data <= d[7:0];
        end else if (pop) begin
            hold_vld  <= 1'b0;
        end
    end
`endif

    // Register file: divisor lanes, sticky overflow, registered read data.
    always_comb begin
        status                                           = '0;
        status[UART_STAT_FULL]                           = fifo_full;
        status[UART_STAT_IDLE]                           = fifo_empty && (state == UART_ST_IDLE);
        status[UART_STAT_OVF]                            = ovf;
        status[UART_STAT_CNT_LSB +: UART_STAT_CNT_W]     = cnt_stat;
    end

    always_comb begin
        rdata = '0;
        case (addr)
            UART_REG_STATUS:  rdata = status;
            UART_REG_DIVISOR: rdata = {16'h0000, div};
            default:          rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= DIV_RESET;
            ovf <= 1'b0;
            q   <= '0;
        end else begin
            if (wr && addr == UART_REG_DIVISOR) begin
                if (we[0]) div[7:0]  <= d[7:0];
                if (we[1]) div[15:8] <= d[15:8];
            end
            if (push && fifo_full && !pop)
                ovf <= 1'b1;
            else if (wr && addr == UART_REG_STATUS && we[0] && d[UART_STAT_OVF])
                ovf <= 1'b0;
            if (rd) q <= rdata;
        end
    end

    // The stop bit's last cycle may pop directly so frames run back to back.
    assign bit_end = (baud_cnt == 16'd0);
    assign period  = uart_eff_div(div) - 16'd1;
    assign pop     = ~fifo_empty &
                     ((state == UART_ST_IDLE) || (state == UART_ST_STOP && bit_end));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= UART_ST_IDLE;
            tx       <= 1'b1;
            baud_cnt <= 16'd0;
            bit_cnt  <= 3'd0;
            shreg    <= 8'h00;
        end else begin
            case (state)
                UART_ST_IDLE: begin
                    if (pop) begin
                        shreg    <= fifo_dout;
                        bit_cnt  <= 3'd0;
                        baud_cnt <= period;
                        tx       <= 1'b0;
                        state    <= UART_ST_START;
                    end
                end
                UART_ST_START: begin
                    if (bit_end) begin
                        tx       <= shreg[0];
                        baud_cnt <= period;
                        state    <= UART_ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                UART_ST_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= period;
                        if (bit_cnt == 3'd7) begin
                            tx    <= 1'b1;
                            state <= UART_ST_STOP;
                        end else begin
                            shreg   <= {1'b0, shreg[7:1]};
                            tx      <= shreg[1];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                UART_ST_STOP: begin
                    if (bit_end) begin
                        if (pop) begin
                            shreg    <= fifo_dout;
                            bit_cnt  <= 3'd0;
                            baud_cnt <= period;
                            tx       <= 1'b0;
                            state    <= UART_ST_START;
                        end else begin
                            state <= UART_ST_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                default: state <= UART_ST_IDLE;
            endcase
        end
    end

endmodule
